prog_ram: RTL and testbench

Parametrised unified instruction/data memory for the risc-16 core. It adds a handshaked, auto-incrementing program loader, registered read ports, full clear-on-reset and out-of-range detection. It sits between the CPU (fetch and load/store ports) and the external programming host. One FSM arbitrates clearing, CPU run mode and host load mode.

---
 rtl/prog_ram_pkg.sv | 14 +
 rtl/prog_ram_if.sv | 33 +++
 rtl/prog_ram.sv | 142 ++++++++++++++
 tb/tb_prog_ram.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/prog_ram_pkg.sv
// Shared types for the risc-16 unified program/data memory.
// The READ/WRITE encoding is shared with the CPU control unit.
package prog_ram_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    LOAD  = 2'd2
  } state_t;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

endpackage

// File: rtl/prog_ram_if.sv
// CPU fetch/data port and host loader port of prog_ram.
// master = CPU + programming host, slave = the memory.
interface prog_ram_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  logic [ADDR_W-1:0] addr;
  logic              rw;
  logic [DATA_W-1:0] mem_in;
  logic [DATA_W-1:0] data_out;
  logic              pgm;
  logic              ld_start;
  logic [ADDR_W-1:0] ld_base;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              busy;
  logic              err;

  modport master (
    output pc, addr, rw, mem_in, pgm, ld_start, ld_base, ld_valid, ld_data,
    input  ir, data_out, ld_ready, busy, err
  );

  modport slave (
    input  pc, addr, rw, mem_in, pgm, ld_start, ld_base, ld_valid, ld_data,
    output ir, data_out, ld_ready, busy, err
  );

endinterface

// File: rtl/prog_ram.sv
// Unified instruction/data memory with clear-on-reset, a handshaked
// auto-incrementing host loader and two registered read ports.
module prog_ram
  import prog_ram_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 16,
  parameter int DEPTH          = 256,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic        clk,
  input logic        rst,
  prog_ram_if.slave  bus
);

  localparam int              IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);

  state_t            state;
  logic [ADDR_W:0]   ptr;
  logic [ADDR_W:0]   ptr_nxt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              we;
  logic [IDX_W-1:0]  waddr;
  logic [DATA_W-1:0] wdata;

  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] dout_q;
  logic              ld_ready_q;
  logic              busy_q;
  logic              err_q;

  logic              pc_ok;
  logic              addr_ok;
  logic              base_ok;

  assign pc_ok   = {1'b0, bus.pc} < LIMIT;
  assign addr_ok = {1'b0, bus.addr} < LIMIT;
  assign base_ok = {1'b0, bus.ld_base} < LIMIT;

  assign bus.ir       = ir_q;
  assign bus.data_out = dout_q;
  assign bus.ld_ready = ld_ready_q;
  assign bus.busy     = busy_q;
  assign bus.err      = err_q;

  // Single write port: the clear sweep, the CPU and the loader take turns by state.
  always_comb begin
    we      = 1'b0;
    waddr   = ptr[IDX_W-1:0];
    wdata   = '0;
    ptr_nxt = ptr;
    case (state)
      CLEAR: begin
        we      = 1'b1;
        ptr_nxt = ptr + 1'b1;
      end
      RUN: begin
        if (bus.rw == WRITE && addr_ok) begin
          we    = 1'b1;
          waddr = bus.addr[IDX_W-1:0];
          wdata = bus.mem_in;
        end
      end
      LOAD: begin
        if (bus.ld_start) begin
          ptr_nxt = {1'b0, bus.ld_base};
          if (bus.ld_valid && base_ok) begin
            we      = 1'b1;
            waddr   = bus.ld_base[IDX_W-1:0];
            wdata   = bus.ld_data;
            ptr_nxt = {1'b0, bus.ld_base} + 1'b1;
          end
        end else if (bus.ld_valid && ld_ready_q) begin
          we      = 1'b1;
          wdata   = bus.ld_data;
          ptr_nxt = ptr + 1'b1;
        end
      end
      default: ;
    endcase
    if (rst) we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      ptr        <= '0;
      ir_q       <= '0;
      dout_q     <= '0;
      ld_ready_q <= 1'b0;
      busy_q     <= (CLEAR_ON_RESET != 0);
      err_q      <= 1'b0;
    end else begin
      ptr <= ptr_nxt;
      // Out-of-range reads return 0; a write to a bad addr is flagged through the same check.
      if (state == CLEAR) begin
        ir_q   <= '0;
        dout_q <= '0;
      end else begin
        ir_q   <= pc_ok   ? mem[bus.pc[IDX_W-1:0]]   : '0;
        dout_q <= addr_ok ? mem[bus.addr[IDX_W-1:0]] : '0;
        if (!pc_ok || !addr_ok) err_q <= 1'b1;
      end
      case (state)
        CLEAR: begin
          ld_ready_q <= 1'b0;
          if (ptr == LIMIT - 1'b1) begin
            state  <= RUN;
            busy_q <= 1'b0;
          end
        end
        RUN: begin
          if (bus.pgm) begin
            state      <= LOAD;
            busy_q     <= 1'b1;
            ld_ready_q <= ptr < LIMIT;
          end else begin
            ld_ready_q <= 1'b0;
          end
        end
        LOAD: begin
          if (bus.ld_start && !base_ok) err_q <= 1'b1;
          if (bus.pgm) begin
            ld_ready_q <= ptr_nxt < LIMIT;
          end else begin
            state      <= RUN;
            busy_q     <= 1'b0;
            ld_ready_q <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_ram.sv
// Directed self-checking bench for prog_ram (DEPTH=256, clear on reset).
// Inputs change 1ns after each rising edge, outputs are sampled there too.
module tb_prog_ram;
  import prog_ram_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  prog_ram_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  prog_ram #(
    .DATA_W(16),
    .ADDR_W(16),
    .DEPTH(256),
    .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rw_v, input logic [15:0] addr_v,
                               input logic [15:0] din_v, input logic [15:0] pc_v);
    bus.rw     = rw_v;
    bus.addr   = addr_v;
    bus.mem_in = din_v;
    bus.pc     = pc_v;
    tick();
  endtask

  task automatic waitIdle(output int cycles);
    cycles = 0;
    while (bus.busy && cycles < 400) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          n;
    logic [15:0] acc;

    rst          = 1'b1;
    bus.pc       = '0;
    bus.addr     = '0;
    bus.rw       = READ;
    bus.mem_in   = '0;
    bus.pgm      = 1'b0;
    bus.ld_start = 1'b0;
    bus.ld_base  = '0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    tick();
    tick();
    checkOutput("rst_busy", bus.busy, 1);
    checkOutput("rst_ready", bus.ld_ready, 0);
    checkOutput("rst_ir", bus.ir, 0);
    checkOutput("rst_dout", bus.data_out, 0);
    checkOutput("rst_err", bus.err, 0);
    rst = 1'b0;
    waitIdle(n);
    checkOutput("powerup_clear_len", n, 256);

    // Fill the array with nonzero data so the second clear has something to erase
    for (int i = 0; i < 256; i++) applyStimulus(WRITE, 16'(i), 16'hA000 | 16'(i), 16'd0);
    applyStimulus(READ, 16'd100, 16'd0, 16'd0);
    checkOutput("preload_readback", bus.data_out, 16'hA064);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("clear_busy", bus.busy, 1);
    checkOutput("clear_dout", bus.data_out, 0);
    waitIdle(n);
    checkOutput("clear_len", n, 256);
    acc = '0;
    for (int i = 0; i < 256; i++) begin
      applyStimulus(READ, 16'(i), 16'd0, 16'(i));
      acc = acc | bus.data_out | bus.ir;
    end
    checkOutput("clear_sweep", acc, 0);
    checkOutput("clear_err", bus.err, 0);

    // CPU write/read, including read-old-data on a same-address write
    applyStimulus(WRITE, 16'd5, 16'h1234, 16'd5);
    applyStimulus(WRITE, 16'd5, 16'hBEEF, 16'd5);
    checkOutput("rmw_old_dout", bus.data_out, 16'h1234);
    checkOutput("rmw_old_ir", bus.ir, 16'h1234);
    applyStimulus(READ, 16'd5, 16'd0, 16'd5);
    checkOutput("wr_dout", bus.data_out, 16'hBEEF);
    checkOutput("wr_ir", bus.ir, 16'hBEEF);

    // Loader burst with gapped valid, CPU write attempts held throughout
    bus.pgm = 1'b1;
    tick();
    checkOutput("load_busy", bus.busy, 1);
    bus.rw       = WRITE;
    bus.addr     = 16'h20;
    bus.mem_in   = 16'hDEAD;
    bus.ld_start = 1'b1;
    bus.ld_base  = 16'h10;
    tick();
    bus.ld_start = 1'b0;
    checkOutput("load_ready", bus.ld_ready, 1);
    for (int k = 0; k < 4; k++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = 16'h1111 * 16'(k + 1);
      tick();
      bus.ld_valid = 1'b0;
      tick();
    end
    checkOutput("load_ready_end", bus.ld_ready, 1);
    bus.rw  = READ;
    bus.pgm = 1'b0;
    tick();
    checkOutput("load_exit_busy", bus.busy, 0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(READ, 16'h10 + 16'(k), 16'd0, 16'd0);
      checkOutput($sformatf("load_word%0d", k), bus.data_out, 16'h1111 * 16'(k + 1));
    end
    applyStimulus(READ, 16'h20, 16'd0, 16'd0);
    checkOutput("load_cpu_wr_ignored", bus.data_out, 0);

    // Loader reaching the end of memory
    bus.pgm = 1'b1;
    tick();
    bus.ld_start = 1'b1;
    bus.ld_base  = 16'd254;
    tick();
    bus.ld_start = 1'b0;
    checkOutput("eom_ready0", bus.ld_ready, 1);
    bus.ld_valid = 1'b1;
    bus.ld_data  = 16'hA1A1;
    tick();
    checkOutput("eom_ready1", bus.ld_ready, 1);
    bus.ld_data = 16'hA2A2;
    tick();
    checkOutput("eom_ready2", bus.ld_ready, 0);
    bus.ld_data = 16'hA3A3;
    tick();
    checkOutput("eom_ready3", bus.ld_ready, 0);
    bus.ld_valid = 1'b0;
    bus.pgm      = 1'b0;
    tick();
    checkOutput("eom_err", bus.err, 0);
    applyStimulus(READ, 16'd254, 16'd0, 16'd0);
    checkOutput("eom_254", bus.data_out, 16'hA1A1);
    applyStimulus(READ, 16'd255, 16'd0, 16'd0);
    checkOutput("eom_255", bus.data_out, 16'hA2A2);
    applyStimulus(READ, 16'd0, 16'd0, 16'd255);
    checkOutput("eom_no_wrap", bus.data_out, 0);
    checkOutput("eom_ir", bus.ir, 16'hA2A2);

    // Out-of-range CPU write and fetch; 300 aliases to 44 if the index were truncated
    applyStimulus(WRITE, 16'd300, 16'h5555, 16'd300);
    checkOutput("oor_ir", bus.ir, 0);
    checkOutput("oor_dout", bus.data_out, 0);
    checkOutput("oor_err", bus.err, 1);
    applyStimulus(READ, 16'd44, 16'd0, 16'd44);
    checkOutput("oor_no_alias", bus.data_out, 0);
    repeat (3) tick();
    checkOutput("oor_err_sticky", bus.err, 1);

    // Reset in the middle of a load
    bus.pgm = 1'b1;
    tick();
    bus.ld_start = 1'b1;
    bus.ld_base  = 16'h40;
    tick();
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b1;
    bus.ld_data  = 16'h7777;
    tick();
    bus.addr    = 16'h40;
    bus.ld_data = 16'h8888;
    tick();
    checkOutput("mid_read_through", bus.data_out, 16'h7777);
    rst         = 1'b1;
    bus.ld_data = 16'h9999;
    tick();
    rst          = 1'b0;
    bus.ld_valid = 1'b0;
    bus.pgm      = 1'b0;
    checkOutput("mid_busy", bus.busy, 1);
    checkOutput("mid_ready", bus.ld_ready, 0);
    checkOutput("mid_err", bus.err, 0);
    waitIdle(n);
    checkOutput("mid_clear_len", n, 256);
    acc = '0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(READ, 16'h40 + 16'(k), 16'd0, 16'h40 + 16'(k));
      acc = acc | bus.data_out | bus.ir;
    end
    checkOutput("mid_cleared", acc, 0);
    checkOutput("mid_err_after", bus.err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
